traffic_phase_controller: RTL
=============================

Name: traffic_phase_controller

Overview:
Fully synchronous N-approach intersection controller. It is the parametrised successor to the two-road gated-clock controller.
- Vehicle greens rotate round-robin across NUM_APPROACHES approaches.
- Pedestrian requests are latched and served by an exclusive all-red walk phase.
- Emergency preemption grants green to the requesting approach.
- All timing is counted in tick strobes on one clock. There is no clock gating and there are no internal edge-triggered enables.

Parameters:
NUM_APPROACHES, 4, number of approaches (2..8)
GREEN_TICKS, 30, normal green duration in ticks (>=1)
YELLOW_TICKS, 5, yellow duration (>=1)
ALLRED_TICKS, 2, all-red clearance duration (>=1)
WALK_TICKS, 20, pedestrian walk duration (>=1)
CLEAR_TICKS, 5, pedestrian clearance (buzzer) duration (>=1)
EMERG_MIN_TICKS, 10, minimum emergency green hold (>=1)
TW, $clog2(max duration)+1, timer width (derived; do not override)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
tick  in  1  one-cycle time-base strobe (e.g. 1 Hz); all timers advance only on tick
ped_req  in  NUM_APPROACHES  pedestrian buttons, level, one per crossing
emerg_req  in  NUM_APPROACHES  emergency request per approach, level
light  out  3*NUM_APPROACHES  per-approach one-hot {GREEN,YELLOW,RED}; approach i at [3i+2:3i]
walk  out  NUM_APPROACHES  walk lamp per crossing
buzzer  out  NUM_APPROACHES  audible warning per crossing
active_idx  out  $clog2(NUM_APPROACHES)  approach currently owning or next owning green
emerg_active  out  1  high while in a preemption sequence
ped_pending  out  NUM_APPROACHES  latched, unserved pedestrian requests

Behaviour:
- Reset values (asynchronous):
  - state=ALL_RED, timer=ALLRED_TICKS-1, active_idx=0.
  - All light fields RED (3'b001); walk=0, buzzer=0, emerg_active=0, ped_pending=0.
- States: ALL_RED, GREEN, YELLOW, PED_WALK, PED_CLEAR, EMERG_GREEN.
- Timer rule:
  - On state entry, timer loads D-1.
  - On a cycle with tick=1: if timer==0, take the transition; otherwise decrement.
  - Every state therefore lasts exactly D ticks. With tick tied high, that is D cycles.
- Transitions with no emergency:
  - ALL_RED -> PED_WALK if ped_pending!=0, else GREEN(active_idx).
  - GREEN -> YELLOW.
  - YELLOW -> ALL_RED, with active_idx <= (active_idx+1) mod N.
  - PED_WALK -> PED_CLEAR -> ALL_RED. active_idx is unchanged, so the rotation resumes at the same approach.
- Pedestrian latch:
  - ped_pending |= ped_req every cycle.
  - On entry to PED_WALK, ped_pending is copied into served[] and cleared.
  - A press in the same cycle as the clear survives: set wins.
  - walk[i]=served[i] in PED_WALK and PED_CLEAR; buzzer[i]=served[i] in PED_CLEAR only.
- Emergency target: the lowest-index set bit of emerg_req, captured as emerg_idx at preempt time.
  - In GREEN with active_idx==emerg_idx: go directly to EMERG_GREEN; no yellow.
  - In GREEN with a different approach: go immediately to YELLOW, timer reloads.
  - In YELLOW or ALL_RED: complete normally. Leaving ALL_RED, go to EMERG_GREEN, not PED_WALK; pedestrian requests stay pending.
  - In PED_WALK: go immediately to PED_CLEAR, full CLEAR_TICKS.
- EMERG_GREEN:
  - The emerg_idx approach is GREEN; all others are RED.
  - Exit when the timer has expired (EMERG_MIN_TICKS) AND emerg_req[emerg_idx]==0. Then go to YELLOW, with the next active_idx = emerg_idx+1 mod N.
  - Other emergency requests are ignored until exit. If they are still asserted after ALL_RED, they preempt again.
- emerg_active: set on preempt decision, cleared on the ALL_RED exit following EMERG_GREEN.
- Lights outside GREEN, YELLOW and EMERG_GREEN: all RED. In any state, exactly one approach at most is non-RED.
- tick=0: no state change, no timer change; the latches still operate.
- Reset mid-phase: immediate return to the reset values, regardless of state.

Decomposition:
- Shared package traffic_pkg holds:
  - the state enum;
  - light encodings RED=3'b001, YELLOW=3'b010, GREEN=3'b100;
  - the function lowest_set_index(vec).
- Sub-module phase_timer: inputs load, load_val[TW], tick; output done (timer==0 && tick).
- The controller instantiates one phase_timer.

Test Plan:
All scenarios use N=2, GREEN=4, YELLOW=2, ALLRED=1, WALK=3, CLEAR=2, EMERG_MIN=3, tick=1 unless stated.
- Idle rotation: release reset -> 1 cycle all red; light[2:0]=GREEN for 4 cycles; YELLOW for 2; 1 all red; light[5:3]=GREEN, active_idx=1.
- Pedestrian: pulse ped_req=2'b01 one cycle during approach-0 GREEN -> ped_pending=01 until the next ALL_RED ends. Then walk=01 for 3 cycles, then walk=01 and buzzer=01 for 2 cycles, then GREEN on approach 1. ped_pending=00 after entry.
- Preempt other approach: emerg_req=2'b10 asserted in cycle 2 of approach-0 GREEN -> YELLOW next cycle (2 cycles), ALL_RED (1), then approach-1 GREEN. Hold emerg_req for 10 cycles -> green persists until deassert, plus the remaining minimum; emerg_active high throughout.
- Preempt same approach: emerg_req=2'b01 during approach-0 GREEN -> EMERG_GREEN with no yellow. Deassert after 1 cycle -> green lasts exactly 3 cycles from entry, then YELLOW; next green is approach 1.
- Emergency during walk plus tick gating: emerg_req during PED_WALK -> PED_CLEAR for 2 cycles with buzzer on. Then, with tick pulsing every 4th cycle, ALL_RED lasts 1 tick (4 cycles), followed by EMERG_GREEN.
- Asynchronous reset mid-YELLOW -> same cycle: all RED, walk=0, emerg_active=0, ped_pending=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types, light encodings and helpers for the traffic phase controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        StAllRed,
        StGreen,
        StYellow,
        StPedWalk,
        StPedClear,
        StEmergGreen
    } state_t;

    localparam logic [2:0] LightRed    = 3'b001;
    localparam logic [2:0] LightYellow = 3'b010;
    localparam logic [2:0] LightGreen  = 3'b100;

    localparam int unsigned MaxApproaches = 8;

    function automatic logic [2:0] lowest_set_index(input logic [MaxApproaches-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = MaxApproaches - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Per-phase down-counter; done marks the tick on which the current phase expires.
module phase_timer #(
    parameter int unsigned   TW        = 8,
    parameter logic [TW-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] timer_q;

    assign done = tick && (timer_q == '0);

    // Holds at zero once expired so a held phase keeps reporting done on every tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= RESET_VAL;
        end else if (load) begin
            timer_q <= load_val;
        end else if (tick && (timer_q != '0)) begin
            timer_q <= timer_q - 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach intersection controller: round-robin greens, exclusive pedestrian walk phase,
// and emergency preemption, all timed in tick strobes on a single clock.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_APPROACHES  = 4,
    parameter int unsigned GREEN_TICKS     = 30,
    parameter int unsigned YELLOW_TICKS    = 5,
    parameter int unsigned ALLRED_TICKS    = 2,
    parameter int unsigned WALK_TICKS      = 20,
    parameter int unsigned CLEAR_TICKS     = 5,
    parameter int unsigned EMERG_MIN_TICKS = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic [NUM_APPROACHES-1:0]         ped_req,
    input  logic [NUM_APPROACHES-1:0]         emerg_req,
    output logic [3*NUM_APPROACHES-1:0]       light,
    output logic [NUM_APPROACHES-1:0]         walk,
    output logic [NUM_APPROACHES-1:0]         buzzer,
    output logic [$clog2(NUM_APPROACHES)-1:0] active_idx,
    output logic                              emerg_active,
    output logic [NUM_APPROACHES-1:0]         ped_pending
);

    localparam int unsigned IdxW     = $clog2(NUM_APPROACHES);
    localparam int unsigned MaxTicks =
        max_int(max_int(max_int(GREEN_TICKS, YELLOW_TICKS), max_int(ALLRED_TICKS, WALK_TICKS)),
                max_int(CLEAR_TICKS, EMERG_MIN_TICKS));
    localparam int unsigned TW       = $clog2(MaxTicks) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_APPROACHES - 1);

    state_t                      state_q, state_d;
    logic [IdxW-1:0]             active_q, active_d, eidx_q, eidx_d, req_idx;
    logic                        eactive_q, eactive_d, edone_q, edone_d;
    logic [NUM_APPROACHES-1:0]   pending_q, pending_d, served_q, served_d;
    logic [NUM_APPROACHES-1:0]   walk_q, walk_d, buzzer_q, buzzer_d;
    logic [3*NUM_APPROACHES-1:0] light_q, light_d;
    logic                        load, done, decide;
    logic [TW-1:0]               load_val;

    assign req_idx = IdxW'(lowest_set_index(MaxApproaches'(emerg_req)));
    assign decide  = tick && !eactive_q && (|emerg_req);

    phase_timer #(
        .TW        (TW),
        .RESET_VAL (TW'(ALLRED_TICKS - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        eidx_d    = eidx_q;
        eactive_d = eactive_q;
        edone_d   = edone_q;
        pending_d = pending_q | ped_req;
        served_d  = served_q;
        load      = 1'b0;
        load_val  = '0;

        if (decide) begin
            eactive_d = 1'b1;
            eidx_d    = req_idx;
        end

        if (tick) begin
            unique case (state_q)
                StAllRed: begin
                    if (done) begin
                        // A finished preemption ends here; a still-asserted request re-preempts.
                        if (edone_q) begin
                            eactive_d = |emerg_req;
                            edone_d   = 1'b0;
                            eidx_d    = req_idx;
                        end
                        load = 1'b1;
                        if (eactive_d) begin
                            state_d  = StEmergGreen;
                            active_d = eidx_d;
                            load_val = TW'(EMERG_MIN_TICKS - 1);
                        end else if (|pending_q) begin
                            state_d   = StPedWalk;
                            served_d  = pending_q;
                            pending_d = ped_req;
                            load_val  = TW'(WALK_TICKS - 1);
                        end else begin
                            state_d  = StGreen;
                            load_val = TW'(GREEN_TICKS - 1);
                        end
                    end
                end
                StGreen: begin
                    if (decide && (req_idx == active_q)) begin
                        state_d  = StEmergGreen;
                        load     = 1'b1;
                        load_val = TW'(EMERG_MIN_TICKS - 1);
                    end else if (decide || done) begin
                        state_d  = StYellow;
                        load     = 1'b1;
                        load_val = TW'(YELLOW_TICKS - 1);
                    end
                end
                StYellow: begin
                    if (done) begin
                        state_d  = StAllRed;
                        active_d = (active_q == LastIdx) ? '0 : active_q + 1'b1;
                        load     = 1'b1;
                        load_val = TW'(ALLRED_TICKS - 1);
                    end
                end
                StPedWalk: begin
                    if (decide || done) begin
                        state_d  = StPedClear;
                        load     = 1'b1;
                        load_val = TW'(CLEAR_TICKS - 1);
                    end
                end
                StPedClear: begin
                    if (done) begin
                        state_d  = StAllRed;
                        load     = 1'b1;
                        load_val = TW'(ALLRED_TICKS - 1);
                    end
                end
                StEmergGreen: begin
                    if (done && !emerg_req[eidx_q]) begin
                        state_d  = StYellow;
                        edone_d  = 1'b1;
                        load     = 1'b1;
                        load_val = TW'(YELLOW_TICKS - 1);
                    end
                end
                default: begin
                    state_d  = StAllRed;
                    load     = 1'b1;
                    load_val = TW'(ALLRED_TICKS - 1);
                end
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        for (int i = 0; i < NUM_APPROACHES; i++) light_d[3*i +: 3] = LightRed;
        if (state_d == StGreen || state_d == StEmergGreen) begin
            light_d[3*int'(active_d) +: 3] = LightGreen;
        end else if (state_d == StYellow) begin
            light_d[3*int'(active_d) +: 3] = LightYellow;
        end
        walk_d   = (state_d == StPedWalk || state_d == StPedClear) ? served_d : '0;
        buzzer_d = (state_d == StPedClear) ? served_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StAllRed;
            active_q  <= '0;
            eidx_q    <= '0;
            eactive_q <= 1'b0;
            edone_q   <= 1'b0;
            pending_q <= '0;
            served_q  <= '0;
            light_q   <= {NUM_APPROACHES{LightRed}};
            walk_q    <= '0;
            buzzer_q  <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            eidx_q    <= eidx_d;
            eactive_q <= eactive_d;
            edone_q   <= edone_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            light_q   <= light_d;
            walk_q    <= walk_d;
            buzzer_q  <= buzzer_d;
        end
    end

    assign light        = light_q;
    assign walk         = walk_q;
    assign buzzer       = buzzer_q;
    assign active_idx   = active_q;
    assign emerg_active = eactive_q;
    assign ped_pending  = pending_q;

endmodule
